fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_3000, address of first fetch after reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pc_out  output  32  address currently being fetched; drives the next-PC unit's addr input.
REQ-005 npc  input  32  next address from the next-PC unit, valid combinationally from pc_out; carries the branch/jump target when redirect=1.
REQ-006 redirect  input  1  one-cycle pulse: npc is a taken target; squash younger work.
REQ-007 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  request address, equals pc_out.
REQ-010 imem_ack  input  1  read data valid this cycle; may assert in the same cycle as imem_req (zero-wait).
REQ-011 imem_rdata  input  32  instruction word, qualified by imem_ack.
REQ-012 id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 id_instr  output  32  instruction word to decode.
REQ-014 id_pc  output  32  address of id_instr.

Function
REQ-015 FSM states: IDLE, FETCH, HOLD.
REQ-016 IDLE: entered on reset; imem_req=0; next state is FETCH unconditionally.
REQ-017 FETCH: imem_req=1 and imem_addr=pc_out.
REQ-018 imem_addr SHALL stay stable while imem_req=1 and imem_ack=0, even across redirect.
REQ-019 Accept: FETCH and imem_ack=1 and squash=0 and (id_valid=0 or stall=0).
- Effect: id_instr<=imem_rdata, id_pc<=pc_out, id_valid<=1, pc<=npc.
REQ-020 FETCH and imem_ack=1 and stall=1 and id_valid=1: the word SHALL be held in a one-entry skid register; state goes to HOLD.
REQ-021 HOLD: imem_req=0; on stall=0, the skid entry moves to IF/ID, pc<=npc and state returns to FETCH.
REQ-022 Without an accept, stall=0 clears id_valid (bubble); stall=1 holds all id_* outputs unchanged.
REQ-023 Redirect with no ack pending: IF/ID and skid are invalidated, pc<=npc, state goes to FETCH.
REQ-024 Redirect while a request is outstanding (FETCH, ack=0): latch npc into target, set squash.
- When the ack arrives: discard the data, pc<=target, clear squash, issue a new request next cycle.
REQ-025 Redirect coincident with imem_ack: the returned data is discarded, pc<=npc, no squash flag.
REQ-026 Redirect has priority over stall and over accept; id_valid=0 in the cycle after a redirect.
REQ-027 Arithmetic: the PC is a full 32-bit value with no wrap checking; the low 2 bits are forced to 00 on load.
REQ-028 Throughput is 1 instruction/cycle with zero-wait memory and no stall; fetch-to-id_valid latency is 1 cycle after ack.

Reset
REQ-029 rst_n=0 asynchronously forces:
- pc=RESET_PC, state=IDLE.
- id_valid=0, id_instr=0, id_pc=0.
- skid invalid, squash=0, target=0, imem_req=0.
REQ-030 Reset asserted mid-request SHALL abandon the transaction; a late imem_ack after reset release in IDLE SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2 bits), RESET_PC default and the NOP encoding 32'h0000_0000.
REQ-032 The one-entry skid buffer SHALL be a sub-module named fetch_skid_buf (valid/instr/pc, load/pop/flush).

Verification
REQ-033 Reset release with zero-wait ack and npc=pc_out+4 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; id_valid high from cycle 2.
REQ-034 Ack delayed 3 cycles at 0x3004 -> imem_addr held at 0x3004 for 4 cycles; id_valid low during the wait.
REQ-035 stall=1 for 2 cycles with id_pc=0x3004 -> id_* frozen, 0x3008 held in skid, imem_req=0; on release id_pc=0x3008 with no lost or duplicated word.
REQ-036 redirect with npc=0x3100 while the 0x3008 ack is pending -> 0x3008 data discarded, next request at 0x3100, id_valid=0 until the 0x3100 ack.
REQ-037 redirect coincident with ack, npc=0x0040_0000 -> next imem_addr 0x0040_0000, no squashed word reaches ID.
REQ-038 rst_n pulsed low mid-wait -> all outputs return to reset values immediately; the first request after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared encodings and constants for the fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry skid register catching a word that decode cannot take yet.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, imem request FSM and IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  target_q;
  logic         squash_q;
  logic         imem_req_q;
  logic         id_valid_q;
  logic [31:0]  id_instr_q;
  logic [31:0]  id_pc_q;

  logic         accept;
  logic         skid_load;
  logic         skid_pop;
  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  always_comb begin
    accept    = 1'b0;
    skid_load = 1'b0;
    skid_pop  = 1'b0;
    if (state_q == ST_FETCH && !redirect && !squash_q && imem_ack) begin
      accept    = !id_valid_q || !stall;
      skid_load = id_valid_q && stall;
    end
    if (state_q == ST_HOLD && !redirect && !stall)
      skid_pop = 1'b1;
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .flush_i (redirect),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= align_pc(RESET_PC);
      target_q   <= 32'h0;
      squash_q   <= 1'b0;
      imem_req_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0;
    end else begin
      // Bubble unless something below loads IF/ID; a stall freezes it.
      if (redirect || !stall)
        id_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
          if (redirect)
            pc_q <= align_pc(npc);
        end

        ST_FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              pc_q     <= align_pc(npc);
              squash_q <= 1'b0;
            end else begin
              // Keep imem_addr stable until the outstanding ack returns.
              target_q <= align_pc(npc);
              squash_q <= 1'b1;
            end
          end else if (squash_q) begin
            if (imem_ack) begin
              pc_q     <= target_q;
              squash_q <= 1'b0;
            end
          end else if (accept) begin
            id_valid_q <= 1'b1;
            id_instr_q <= imem_rdata;
            id_pc_q    <= pc_q;
            pc_q       <= align_pc(npc);
          end else if (skid_load) begin
            state_q    <= ST_HOLD;
            imem_req_q <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (redirect) begin
            pc_q       <= align_pc(npc);
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end else if (skid_pop) begin
            id_valid_q <= skid_valid;
            id_instr_q <= skid_instr;
            id_pc_q    <= skid_pc;
            pc_q       <= align_pc(npc);
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out    = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = imem_req_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] npc;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] redir_npc = 32'h0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign npc        = redirect ? redir_npc : pc_out + 32'd4;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_out     (pc_out),
    .npc        (npc),
    .redirect   (redirect),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b1; stall = 1'b0; redirect = 1'b0;
    step();
    compared++; if (pc_out !== 32'h3000) begin mismatched++; $display("FAIL rst_pc got %h want %h", pc_out, 32'h3000); end
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req got %b want 0", imem_req); end
    compared++; if (id_valid !== 1'b0) begin mismatched++; $display("FAIL rst_id_valid got %b want 0", id_valid); end
    compared++; if (id_instr !== 32'h0) begin mismatched++; $display("FAIL rst_id_instr got %h want 0", id_instr); end
    compared++; if (id_pc !== 32'h0) begin mismatched++; $display("FAIL rst_id_pc got %h want 0", id_pc); end
  endtask

  task automatic test_throughput();
    do_reset();
    imem_ack = 1'b1;
    step();
    compared++; if (imem_addr !== 32'h3000 || imem_req !== 1'b1) begin mismatched++; $display("FAIL tp_c1 got addr %h req %b want 3000/1", imem_addr, imem_req); end
    compared++; if (id_valid !== 1'b0) begin mismatched++; $display("FAIL tp_c1_valid got %b want 0", id_valid); end
    step();
    compared++; if (imem_addr !== 32'h3004) begin mismatched++; $display("FAIL tp_c2_addr got %h want 3004", imem_addr); end
    compared++; if (id_valid !== 1'b1 || id_pc !== 32'h3000 || id_instr !== 32'hDEAD3000) begin mismatched++; $display("FAIL tp_c2_id got %b %h %h want 1 3000 dead3000", id_valid, id_pc, id_instr); end
    step();
    compared++; if (imem_addr !== 32'h3008) begin mismatched++; $display("FAIL tp_c3_addr got %h want 3008", imem_addr); end
    compared++; if (id_valid !== 1'b1 || id_pc !== 32'h3004) begin mismatched++; $display("FAIL tp_c3_id got %b %h want 1 3004", id_valid, id_pc); end
  endtask

  task automatic test_ack_delay();
    do_reset();
    imem_ack = 1'b1;
    step();
    step();
    compared++; if (imem_addr !== 32'h3004) begin mismatched++; $display("FAIL dly_start got %h want 3004", imem_addr); end
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++; if (imem_addr !== 32'h3004 || imem_req !== 1'b1 || id_valid !== 1'b0) begin mismatched++; $display("FAIL dly_wait%0d got addr %h req %b valid %b want 3004 1 0", i, imem_addr, imem_req, id_valid); end
    end
    imem_ack = 1'b1;
    step();
    compared++; if (imem_addr !== 32'h3008 || id_valid !== 1'b1 || id_pc !== 32'h3004) begin mismatched++; $display("FAIL dly_done got %h %b %h want 3008 1 3004", imem_addr, id_valid, id_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ack = 1'b1;
    step(); step(); step();
    compared++; if (id_pc !== 32'h3004 || imem_addr !== 32'h3008) begin mismatched++; $display("FAIL st_pre got id_pc %h addr %h want 3004 3008", id_pc, imem_addr); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++; if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h3004 || id_instr !== 32'hDEAD3004) begin mismatched++; $display("FAIL st_hold%0d got req %b valid %b pc %h instr %h want 0 1 3004 dead3004", i, imem_req, id_valid, id_pc, id_instr); end
    end
    stall = 1'b0;
    step();
    compared++; if (id_valid !== 1'b1 || id_pc !== 32'h3008 || id_instr !== 32'hDEAD3008) begin mismatched++; $display("FAIL st_release got %b %h %h want 1 3008 dead3008", id_valid, id_pc, id_instr); end
    compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C) begin mismatched++; $display("FAIL st_refetch got req %b addr %h want 1 300c", imem_req, imem_addr); end
    step();
    compared++; if (id_valid !== 1'b1 || id_pc !== 32'h300C) begin mismatched++; $display("FAIL st_next got %b %h want 1 300c", id_valid, id_pc); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    imem_ack = 1'b1;
    step(); step(); step();
    imem_ack = 1'b0; redirect = 1'b1; redir_npc = 32'h0000_3100;
    step();
    redirect = 1'b0;
    compared++; if (imem_addr !== 32'h3008 || imem_req !== 1'b1 || id_valid !== 1'b0) begin mismatched++; $display("FAIL rp_stable got %h %b %b want 3008 1 0", imem_addr, imem_req, id_valid); end
    step();
    compared++; if (imem_addr !== 32'h3008 || id_valid !== 1'b0) begin mismatched++; $display("FAIL rp_wait got %h %b want 3008 0", imem_addr, id_valid); end
    imem_ack = 1'b1;
    step();
    compared++; if (imem_addr !== 32'h3100 || id_valid !== 1'b0) begin mismatched++; $display("FAIL rp_discard got %h %b want 3100 0", imem_addr, id_valid); end
    step();
    compared++; if (id_valid !== 1'b1 || id_pc !== 32'h3100 || id_instr !== 32'hDEAD3100) begin mismatched++; $display("FAIL rp_target got %b %h %h want 1 3100 dead3100", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    imem_ack = 1'b1;
    step(); step();
    redirect = 1'b1; redir_npc = 32'h0040_0000;
    step();
    redirect = 1'b0;
    compared++; if (imem_addr !== 32'h0040_0000 || id_valid !== 1'b0) begin mismatched++; $display("FAIL ra_addr got %h %b want 00400000 0", imem_addr, id_valid); end
    step();
    compared++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0000) begin mismatched++; $display("FAIL ra_id got %b %h want 1 00400000", id_valid, id_pc); end
    redirect = 1'b1; redir_npc = 32'h0000_5007;
    step();
    redirect = 1'b0;
    compared++; if (imem_addr !== 32'h0000_5004) begin mismatched++; $display("FAIL ra_align got %h want 5004", imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ack = 1'b1;
    step(); step();
    imem_ack = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    compared++; if (pc_out !== 32'h3000 || imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin mismatched++; $display("FAIL rm_async got pc %h req %b valid %b id_pc %h instr %h want 3000 0 0 0 0", pc_out, imem_req, id_valid, id_pc, id_instr); end
    imem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    compared++; if (imem_addr !== 32'h3000 || imem_req !== 1'b1 || id_valid !== 1'b0) begin mismatched++; $display("FAIL rm_first got %h %b %b want 3000 1 0", imem_addr, imem_req, id_valid); end
    step();
    compared++; if (id_valid !== 1'b1 || id_pc !== 32'h3000) begin mismatched++; $display("FAIL rm_accept got %b %h want 1 3000", id_valid, id_pc); end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_ack_delay();
    test_stall();
    test_redirect_pending();
    test_redirect_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
